softmax_seq_ctrl: RTL and testbench

- Sequential, resource-shared softmax engine that computes the same function as the combinational fixed-point softmax.
- Accepts one SIZE-element logit vector as a valid/ready stream and returns SIZE probabilities as a valid/ready stream.
- One exp unit and one divider are time-multiplexed across elements under an FSM.
- Sits between the final dense layer output stream and the classifier/argmax stage.

---
 rtl/softmax_pkg.sv | 18 +
 rtl/softmax_exp_unit.sv | 38 +++
 rtl/softmax_seq_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_softmax_seq_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared types and constants for the sequential softmax engine.
package softmax_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXP,
        NORM,
        ADJ,
        OUT
    } state_e;

    localparam int MIN_X_MULT   = 2;
    localparam int TAYLOR_ORDER = 6;

    typedef logic signed [31:0] acc_t;

endpackage

// File: rtl/softmax_exp_unit.sv
// Combinational fixed-point exp(x) for x <= 0: input clipped to -MIN_X_MULT,
// then a Taylor series of order TAYLOR_ORDER, negative results clamped to 0.
module softmax_exp_unit
    import softmax_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] y
);

    localparam acc_t MIN_X = -(acc_t'(MIN_X_MULT) <<< FRAC);
    localparam acc_t ONE   = acc_t'(1) <<< FRAC;

    acc_t xc;
    acc_t term;
    acc_t total;

    always_comb begin
        xc = acc_t'(x);
        if (xc < MIN_X) begin
            xc = MIN_X;
        end
        term  = xc;
        total = ONE + xc;
        // Each term is derived from the previous one: t_k = (t_(k-1) * x >> FRAC) / k.
        for (int k = 2; k <= TAYLOR_ORDER; k++) begin
            term  = ((term * xc) >>> FRAC) / acc_t'(k);
            total = total + term;
        end
        if (total < 0) begin
            total = '0;
        end
        y = WIDTH'(total);
    end

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Resource-shared softmax: one exp unit and one divider walk the vector under an FSM.
// Optional perf counters are built when SOFTMAX_SEQ_CTRL_PERF_EN is defined.
module softmax_seq_ctrl
    import softmax_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int SIZE  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic                    busy
`ifdef SOFTMAX_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]             perf_cycles,
    output logic [15:0]             perf_vectors
`endif
);

    // Both streams use valid/ready: a beat transfers on a rising clk edge where
    // valid and ready are both high; the source holds its beat until then.

    localparam int                IDXW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [IDXW-1:0]   LAST = IDXW'(SIZE - 1);
    localparam acc_t              ONE  = acc_t'(1) <<< FRAC;

    state_e                  state;
    logic [IDXW-1:0]         idx;
    logic [IDXW-1:0]         idx_nxt;
    logic signed [WIDTH-1:0] lbuf [SIZE];
    logic signed [WIDTH-1:0] ex_q [SIZE];
    logic signed [WIDTH-1:0] p_q  [SIZE];
    logic signed [WIDTH-1:0] max_q;
    acc_t                    sum_q;

    logic signed [WIDTH-1:0] sub;
    logic signed [WIDTH-1:0] exp_y;
    acc_t                    norm_num;
    acc_t                    norm_div;
    logic signed [WIDTH-1:0] p_new;
    acc_t                    adj_sum;
    logic signed [WIDTH-1:0] adj_max;
    logic [IDXW-1:0]         adj_idx;
    logic signed [WIDTH-1:0] adj_val;

    assign idx_nxt = idx + IDXW'(1);
    assign sub     = lbuf[idx] - max_q;

    softmax_exp_unit #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_exp (
        .x (sub),
        .y (exp_y)
    );

    // Shared divider, rounding to nearest by pre-adding half the divisor.
    always_comb begin
        norm_num = (acc_t'(ex_q[idx]) <<< FRAC) + (sum_q >>> 1);
        norm_div = (sum_q == '0) ? '0 : norm_num / sum_q;
        p_new    = WIDTH'(norm_div);
    end

    // Rounding residue goes to the lowest-index largest probability.
    always_comb begin
        adj_sum = acc_t'(p_q[0]);
        adj_max = p_q[0];
        adj_idx = '0;
        for (int i = 1; i < SIZE; i++) begin
            adj_sum = adj_sum + acc_t'(p_q[i]);
            if (p_q[i] > adj_max) begin
                adj_max = p_q[i];
                adj_idx = IDXW'(i);
            end
        end
        adj_val = WIDTH'(acc_t'(adj_max) + ONE - adj_sum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            sum_q     <= '0;
            max_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        lbuf[0] <= in_data;
                        max_q   <= in_data;
                        idx     <= IDXW'(1);
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        lbuf[idx] <= in_data;
                        if (in_data > max_q) begin
                            max_q <= in_data;
                        end
                        if (idx == LAST) begin
                            idx      <= '0;
                            sum_q    <= '0;
                            in_ready <= 1'b0;
                            state    <= EXP;
                        end else begin
                            idx <= idx_nxt;
                        end
                    end
                end
                EXP: begin
                    ex_q[idx] <= exp_y;
                    sum_q     <= sum_q + acc_t'(exp_y);
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= NORM;
                    end else begin
                        idx <= idx_nxt;
                    end
                end
                NORM: begin
                    p_q[idx] <= p_new;
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= ADJ;
                    end else begin
                        idx <= idx_nxt;
                    end
                end
                ADJ: begin
                    p_q[adj_idx] <= adj_val;
                    out_valid    <= 1'b1;
                    out_data     <= (adj_idx == '0) ? adj_val : p_q[0];
                    out_last     <= 1'b0;
                    state        <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        if (idx == LAST) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            idx       <= '0;
                            sum_q     <= '0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            idx      <= idx_nxt;
                            out_data <= p_q[idx_nxt];
                            out_last <= (idx_nxt == LAST);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SOFTMAX_SEQ_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles  <= '0;
            perf_vectors <= '0;
        end else begin
            if (busy && (perf_cycles != '1)) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (out_valid && out_ready && out_last) begin
                perf_vectors <= perf_vectors + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Bench for softmax_seq_ctrl: directed vectors, random vectors against a
// reference model, backpressure, mid-operation reset and back-to-back input.
module tb_softmax_seq_ctrl;

    localparam int WIDTH = 16;
    localparam int FRAC  = 8;
    localparam int SIZE  = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_last;
    logic                    busy;
`ifdef SOFTMAX_SEQ_CTRL_PERF_EN
    logic [31:0]             perf_cycles;
    logic [15:0]             perf_vectors;
`endif

    softmax_seq_ctrl #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .SIZE  (SIZE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
`ifdef SOFTMAX_SEQ_CTRL_PERF_EN
        ,
        .perf_cycles  (perf_cycles),
        .perf_vectors (perf_vectors)
`endif
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] req);
        tests++;
        assert (obs === req)
        else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, req);
        end
    endtask

    // Reference model: softmax computed from the arithmetic rules directly
    function automatic int m_exp(input int x);
        int xc;
        int term;
        int total;
        xc    = (x < -(2 << FRAC)) ? -(2 << FRAC) : x;
        term  = xc;
        total = (1 << FRAC) + xc;
        for (int k = 2; k <= 6; k++) begin
            term  = ((term * xc) >>> FRAC) / k;
            total = total + term;
        end
        return (total < 0) ? 0 : total;
    endfunction

    function automatic void model(input int v[SIZE], output int p[SIZE]);
        int mx;
        int sum;
        int psum;
        int best;
        int e[SIZE];
        mx = v[0];
        foreach (v[i]) if (v[i] > mx) mx = v[i];
        sum = 0;
        foreach (v[i]) begin
            e[i] = m_exp(v[i] - mx);
            sum  = sum + e[i];
        end
        psum = 0;
        best = 0;
        foreach (e[i]) begin
            p[i] = (sum == 0) ? 0 : ((e[i] << FRAC) + (sum >> 1)) / sum;
            psum = psum + p[i];
        end
        foreach (p[i]) if (p[i] > p[best]) best = i;
        p[best] = p[best] + (1 << FRAC) - psum;
    endfunction

    task automatic expect_vec(input int p[SIZE]);
        foreach (p[i]) exp_q.push_back(WIDTH'(p[i]));
    endtask

    // out_ready driver: 0 = always ready, 1 = stall pattern, 2 = random
    int rdy_mode = 0;
    int bp_s = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    out_ready = (bp_s == 0) || (bp_s > 5 && (bp_s % 2 == 1));
                    bp_s++;
                end
                2: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Output monitor / scoreboard
    int beat = 0;
    int ov_rise_cyc = 0;
    int last_hs_cyc = 0;
    logic stall_prev = 1'b0;
    logic prev_valid = 1'b0;
    logic signed [WIDTH-1:0] held_data;
    logic held_last;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            prev_valid = 1'b0;
            beat       = 0;
        end else begin
            if (out_valid) check("in_ready_during_out", in_ready, 0);
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, held_data);
                check("stall_last", out_last, held_last);
            end
            if (out_valid && !prev_valid) ov_rise_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", exp_q.size(), 1);
                end else begin
                    check("out_data", out_data, $signed(exp_q.pop_front()));
                    check("out_last", out_last, (beat == SIZE - 1));
                end
                if (beat == SIZE - 1) begin
                    beat        = 0;
                    last_hs_cyc = cyc + 1;
                end else begin
                    beat++;
                end
            end
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            held_last  = out_last;
            prev_valid = out_valid;
        end
    end

    // Input driver
    int first_in_cyc = 0;
    int in_last_cyc = 0;
    task automatic send_vec(input int v[SIZE], input bit hold_valid);
        logic ok;
        int   n;
        int   hs;
        hs = 0;
        for (int i = 0; i < SIZE; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(v[i]);
            ok = 1'b0;
            n  = 0;
            while (!ok && n < 100) begin
                @(negedge clk);
                ok = in_ready;
                if (ok) hs = cyc + 1;
                @(posedge clk);
                #1;
                n++;
            end
            if (!ok) check("in_handshake_timeout", ok, 1);
            if (i == 0) first_in_cyc = hs;
        end
        in_last_cyc = hs;
        if (!hold_valid) in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    int v[SIZE];
    int a[SIZE];
    int p[SIZE];
    int n;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);
`ifdef SOFTMAX_SEQ_CTRL_PERF_EN
        check("perf_cycles_rst", perf_cycles, 0);
`endif
        @(posedge clk);
        #1;

        // Uniform vector, with latency check
        v = '{0, 0, 0, 0};
        p = '{64, 64, 64, 64};
        expect_vec(p);
        send_vec(v, 1'b0);
        @(negedge clk);
        check("busy_after_load", busy, 1);
        drain("uniform_drain");
        check("latency", ov_rise_cyc - in_last_cyc, 2 * SIZE + 1);

        // One-hot
        v = '{256, 0, 0, 0};
        p = '{121, 45, 45, 45};
        expect_vec(p);
        send_vec(v, 1'b0);
        drain("onehot_drain");

        // Clip path
        v = '{0, -1024, -1024, -1024};
        p = '{175, 27, 27, 27};
        expect_vec(p);
        send_vec(v, 1'b0);
        drain("clip_drain");

        // Backpressure: stall 5 cycles mid-stream then toggle
        foreach (v[i]) v[i] = int'($urandom_range(0, 2048)) - 1024;
        model(v, p);
        expect_vec(p);
        send_vec(v, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", out_valid, 1);
        bp_s     = 0;
        rdy_mode = 1;
        drain("bp_drain");
        rdy_mode = 0;

        // Reset during EXP aborts the vector
        v = '{10, 20, 30, 40};
        send_vec(v, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        repeat (2 * SIZE + 6) @(negedge clk);
        @(posedge clk);
        #1;
        v = '{0, 0, 0, 0};
        p = '{64, 64, 64, 64};
        expect_vec(p);
        send_vec(v, 1'b0);
        drain("post_abort_drain");

        // Random vectors with random backpressure
        rdy_mode = 2;
        for (int t = 0; t < 12; t++) begin
            foreach (v[i]) v[i] = int'($urandom_range(0, 2048)) - 1024;
            model(v, p);
            expect_vec(p);
            send_vec(v, 1'b0);
            drain("random_drain");
        end
        rdy_mode = 0;

        // Back-to-back with in_valid held high; second vector has a tie
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        foreach (a[i]) a[i] = int'($urandom_range(0, 2048)) - 1024;
        model(a, p);
        expect_vec(p);
        v = '{0, 0, 0, -2048};
        p = '{82, 81, 81, 12};
        expect_vec(p);
        send_vec(a, 1'b1);
        send_vec(v, 1'b0);
        check("b2b_accept", first_in_cyc - last_hs_cyc, 1);
        drain("b2b_drain");
`ifdef SOFTMAX_SEQ_CTRL_PERF_EN
        check("perf_vectors", perf_vectors, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global timeout guard
    initial begin
        #500000;
        $display("FAIL timeout: observed no completion required completion");
        $fatal(1, "timeout");
    end

endmodule
